// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared constants, FSM states and region-table helper for rom_loader
package rom_loader_pkg;

    localparam int DEF_ADDR_W      = 19;
    localparam int DEF_OFS_W       = 17;
    localparam int DEF_NUM_REGIONS = 8;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam bit DEF_AUTO_START  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CAPT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // LSB of region idx inside a packed lo/hi table of width-bit fields
    function automatic int region_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - priority match of a window offset against the region table
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int OFS_W       = DEF_OFS_W,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS
) (
    input  logic [OFS_W-1:0]             ofs,
    input  logic [NUM_REGIONS*OFS_W-1:0] region_lo,
    input  logic [NUM_REGIONS*OFS_W-1:0] region_hi,
    output logic [NUM_REGIONS-1:0]       sel,
    output logic                         hit,
    output logic [OFS_W-1:0]             rel_addr
);

    // Scan from the top so the lowest matching index is the one left standing
    always_comb begin
        sel      = '0;
        hit      = 1'b0;
        rel_addr = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (region_lo[region_lsb(i, OFS_W) +: OFS_W] <= ofs &&
                ofs <= region_hi[region_lsb(i, OFS_W) +: OFS_W]) begin
                sel      = NUM_REGIONS'(1) << i;
                hit      = 1'b1;
                rel_addr = ofs - region_lo[region_lsb(i, OFS_W) +: OFS_W];
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time copy of an external ROM window into region-routed block RAMs
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int OFS_W       = DEF_OFS_W,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter bit AUTO_START  = DEF_AUTO_START
) (
    input  logic                         clk_6144,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [OFS_W-1:0]             length,
    input  logic [NUM_REGIONS*OFS_W-1:0] region_lo,
    input  logic [NUM_REGIONS*OFS_W-1:0] region_hi,
    input  logic [ADDR_W-1:0]            run_addr,
    input  logic [7:0]                   rom_d,
    output logic [ADDR_W-1:0]            rom_a,
    output logic [OFS_W-1:0]             dl_addr,
    output logic [7:0]                   dl_data,
    output logic [NUM_REGIONS-1:0]       dl_we,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  checksum,
    output logic                         miss
);

    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                   state;
    logic [ADDR_W-1:0]        base_q;
    logic [ADDR_W-1:0]        rom_a_q;
    logic [OFS_W-1:0]         len_q;
    logic [OFS_W-1:0]         ofs;
    logic [WCW-1:0]           wait_cnt;
    logic [NUM_REGIONS-1:0]   sel;
    logic                     hit;
    logic                     hit_q;
    logic [OFS_W-1:0]         rel_addr;

    rom_region_decode #(
        .OFS_W       (OFS_W),
        .NUM_REGIONS (NUM_REGIONS)
    ) u_decode (
        .ofs       (ofs),
        .region_lo (region_lo),
        .region_hi (region_hi),
        .sel       (sel),
        .hit       (hit),
        .rel_addr  (rel_addr)
    );

    // Once loaded, the machine owns the ROM bus
    assign rom_a = done ? run_addr : rom_a_q;

    always_ff @(posedge clk_6144) begin
        if (reset) begin
            rom_a_q  <= '0;
            dl_addr  <= '0;
            dl_data  <= '0;
            dl_we    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
            miss     <= 1'b0;
            ofs      <= '0;
            wait_cnt <= '0;
            hit_q    <= 1'b1;
            base_q   <= base_addr;
            len_q    <= length;
            if (!AUTO_START)
                state <= ST_IDLE;
            else if (length == '0)
                state <= ST_DONE;
            else
                state <= ST_ADDR;
        end else begin
            dl_we <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (start) begin
                        base_q   <= base_addr;
                        len_q    <= length;
                        ofs      <= '0;
                        checksum <= '0;
                        miss     <= 1'b0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (length == '0) ? ST_DONE : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    rom_a_q  <= base_q + ADDR_W'(ofs);
                    wait_cnt <= '0;
                    busy     <= 1'b1;
                    state    <= (WAIT_CYCLES == 0) ? ST_CAPT : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == WCW'(WAIT_CYCLES - 1))
                        state <= ST_CAPT;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                ST_CAPT: begin
                    // Strobe lands in WRITE with address and data already settled
                    dl_data  <= rom_d;
                    checksum <= checksum + {8'h00, rom_d};
                    dl_addr  <= rel_addr;
                    dl_we    <= sel;
                    hit_q    <= hit;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!hit_q)
                        miss <= 1'b1;
                    if (ofs == len_q - 1'b1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        ofs   <= ofs + 1'b1;
                        state <= ST_ADDR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized self-checking bench for rom_loader against a byte-level model
module tb_rom_loader;

    localparam int ADDR_W = 19;
    localparam int OFS_W  = 17;
    localparam int NR     = 8;
    localparam int WC     = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, start, start2;
    logic [ADDR_W-1:0]    base_addr, run_addr, rom_a, rom_a2;
    logic [OFS_W-1:0]     length, dl_addr, dl_addr2;
    logic [NR*OFS_W-1:0]  region_lo, region_hi;
    logic [7:0]           rom_d, rom_d2, dl_data, dl_data2;
    logic [NR-1:0]        dl_we, dl_we2;
    logic                 busy, done, miss, busy2, done2, miss2;
    logic [15:0]          checksum, checksum2;

    int mul = 1;

    function automatic logic [7:0] rom_byte(input logic [ADDR_W-1:0] a);
        return 8'(int'(a) * mul + 1);
    endfunction

    assign rom_d  = rom_byte(rom_a);
    assign rom_d2 = rom_byte(rom_a2);

    rom_loader #(.ADDR_W(ADDR_W), .OFS_W(OFS_W), .NUM_REGIONS(NR),
                 .WAIT_CYCLES(WC), .AUTO_START(1'b1)) dut (
        .clk_6144 (clk), .reset (reset), .start (start),
        .base_addr (base_addr), .length (length),
        .region_lo (region_lo), .region_hi (region_hi),
        .run_addr (run_addr), .rom_d (rom_d), .rom_a (rom_a),
        .dl_addr (dl_addr), .dl_data (dl_data), .dl_we (dl_we),
        .busy (busy), .done (done), .checksum (checksum), .miss (miss)
    );

    rom_loader #(.ADDR_W(ADDR_W), .OFS_W(OFS_W), .NUM_REGIONS(NR),
                 .WAIT_CYCLES(0), .AUTO_START(1'b0)) dut2 (
        .clk_6144 (clk), .reset (reset), .start (start2),
        .base_addr (base_addr), .length (length),
        .region_lo (region_lo), .region_hi (region_hi),
        .run_addr (run_addr), .rom_d (rom_d2), .rom_a (rom_a2),
        .dl_addr (dl_addr2), .dl_data (dl_data2), .dl_we (dl_we2),
        .busy (busy2), .done (done2), .checksum (checksum2), .miss (miss2)
    );

    logic [NR-1:0]    got_we[$];
    logic [OFS_W-1:0] got_addr[$];
    logic [7:0]       got_data[$];
    int               writes2 = 0;

    always @(negedge clk) begin
        if (dl_we != '0) begin
            got_we.push_back(dl_we);
            got_addr.push_back(dl_addr);
            got_data.push_back(dl_data);
        end
        if (dl_we2 != '0)
            writes2 <= writes2 + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int               lo_t[NR];
    int               hi_t[NR];
    logic [NR-1:0]    exp_we[$];
    logic [OFS_W-1:0] exp_addr[$];
    logic [7:0]       exp_data[$];
    logic [15:0]      exp_sum;
    logic             exp_miss;

    task automatic set_regions_off();
        for (int i = 0; i < NR; i++) begin
            lo_t[i] = 1;
            hi_t[i] = 0;
        end
    endtask

    task automatic pack_regions();
        for (int i = 0; i < NR; i++) begin
            region_lo[i*OFS_W +: OFS_W] = OFS_W'(lo_t[i]);
            region_hi[i*OFS_W +: OFS_W] = OFS_W'(hi_t[i]);
        end
    endtask

    task automatic build_model(input logic [ADDR_W-1:0] base, input int len);
        logic [7:0] b;
        int r;
        exp_we.delete();
        exp_addr.delete();
        exp_data.delete();
        exp_sum  = '0;
        exp_miss = 1'b0;
        for (int o = 0; o < len; o++) begin
            b = rom_byte(ADDR_W'(int'(base) + o));
            exp_sum = exp_sum + 16'(b);
            r = -1;
            for (int i = 0; i < NR; i++) begin
                if (lo_t[i] <= o && o <= hi_t[i]) begin
                    r = i;
                    break;
                end
            end
            if (r < 0) begin
                exp_miss = 1'b1;
            end else begin
                exp_we.push_back(NR'(1) << r);
                exp_addr.push_back(OFS_W'(o - lo_t[r]));
                exp_data.push_back(b);
            end
        end
    endtask

    task automatic wait_done(input int n0, input int exp_n, input bit inject, input string tag);
        int n;
        n = n0;
        while (!done && n < 2000) begin
            if (inject && n == 6) begin
                start  = 1'b1;
                length = length + 3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_cycles"}, n, exp_n);
    endtask

    task automatic compare_writes(input int idx, input string tag);
        check({tag, "_nwr"}, got_we.size() - idx, exp_we.size());
        for (int k = 0; k < exp_we.size() && idx + k < got_we.size(); k++) begin
            check({tag, "_we"},   got_we[idx+k],   exp_we[k]);
            check({tag, "_addr"}, got_addr[idx+k], exp_addr[k]);
            check({tag, "_data"}, got_data[idx+k], exp_data[k]);
        end
        check({tag, "_sum"},  checksum, exp_sum);
        check({tag, "_miss"}, miss, exp_miss);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_load(input logic [ADDR_W-1:0] base, input int len,
                            input bit inject, input string tag);
        int idx;
        build_model(base, len);
        pack_regions();
        base_addr = base;
        length    = OFS_W'(len);
        idx       = got_we.size();
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_fall"}, done, 0);
        wait_done(1, (len == 0) ? 2 : len * (WC + 3) + 1, inject, tag);
        compare_writes(idx, tag);
    endtask

    initial begin
        int idx, n, w0;
        logic [ADDR_W-1:0] rb;

        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        base_addr = '0; length = OFS_W'(8); run_addr = '0;
        set_regions_off();
        lo_t[0] = 0; hi_t[0] = 3;
        lo_t[1] = 4; hi_t[1] = 7;
        pack_regions();
        @(negedge clk);
        @(negedge clk);
        check("rst_we", dl_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", checksum, 0);
        check("rst_miss", miss, 0);
        check("rst_rom_a", rom_a, 0);
        check("rst_done2", done2, 0);

        // Auto-start load straight out of reset
        build_model('0, 8);
        idx = got_we.size();
        reset = 1'b0;
        wait_done(1, 8 * (WC + 3) + 1, 1'b0, "auto");
        compare_writes(idx, "auto");
        check("auto_sum36", checksum, 36);

        run_addr = 19'h01234;
        #1;
        check("run_pass", rom_a, 19'h01234);
        @(negedge clk);

        set_regions_off();
        lo_t[0] = 0; hi_t[0] = 7;
        lo_t[1] = 2; hi_t[1] = 5;
        run_load(19'h00100, 8, 1'b0, "ovl");

        set_regions_off();
        lo_t[0] = 0; hi_t[0] = 1;
        run_load(19'h00200, 4, 1'b0, "gap");

        run_load(19'h00300, 0, 1'b0, "zero");

        mul = 3;
        lo_t[1] = 2; hi_t[1] = 9;
        run_load(19'h00400, 10, 1'b1, "busy_start");

        for (int t = 0; t < 6; t++) begin
            mul = int'($urandom | 1);
            for (int i = 0; i < NR; i++) begin
                lo_t[i] = $urandom_range(0, 23);
                hi_t[i] = $urandom_range(0, 23);
            end
            run_load(ADDR_W'($urandom), $urandom_range(1, 20), 1'b0, "rnd");
        end

        // Reset in the middle of a load that wraps the address space
        set_regions_off();
        lo_t[0] = 0; hi_t[0] = 3;
        lo_t[2] = 4; hi_t[2] = 7;
        pack_regions();
        rb = 19'h7FFFC;
        base_addr = rb;
        length = OFS_W'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rom_a != ADDR_W'(rb + 19'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach", n < 200, 1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_we", dl_we, 0);
            check("mid_rst_done", done, 0);
        end
        build_model(rb, 8);
        idx = got_we.size();
        reset = 1'b0;
        @(negedge clk);
        check("mid_restart_a", rom_a, rb);
        wait_done(2, 8 * (WC + 3) + 1, 1'b0, "mid");
        compare_writes(idx, "mid");

        // Zero-wait-state build started by request
        mul = 5;
        set_regions_off();
        lo_t[3] = 0; hi_t[3] = 5;
        build_model(19'h00050, 9);
        pack_regions();
        base_addr = 19'h00050;
        length = OFS_W'(9);
        w0 = writes2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("w0_cycles", n, 9 * 3 + 1);
        check("w0_sum", checksum2, exp_sum);
        check("w0_miss", miss2, exp_miss);
        check("w0_nwr", writes2 - w0, exp_we.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
